jump_controller: RTL and testbench

Game-logic block that drives the character's jump commands and consumes its `landed` handshake. It turns single-cycle key pulses from the keyboard decoder into `jump_left` / `jump_right` / `jump_fail` command pulses and checks each press against a pseudo-random platform sequence. It enforces a per-step reaction timeout, keeps the score, and raises `game_over` after a failed jump lands.

---
 rtl/jump_controller_pkg.sv | 21 ++
 rtl/jump_controller_lfsr16.sv | 32 +++
 rtl/jump_controller.sv | 145 ++++++++++++++
 tb/tb_jump_controller.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jump_controller_pkg.sv
// Shared types and constants for the jump controller slice.
package jump_controller_pkg;

   typedef enum logic [1:0] {
      S_WAIT = 2'd0,
      S_AIR  = 2'd1,
      S_FALL = 2'd2,
      S_OVER = 2'd3
   } jc_state_t;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   localparam logic [15:0] JC_LFSR_TAPS = 16'hB400;

   // One step of the right-shifting Galois LFSR.
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ JC_LFSR_TAPS) : (v >> 1);
   endfunction

endpackage

// File: rtl/jump_controller_lfsr16.sv
// 16-bit Galois LFSR producing the platform direction sequence.
module lfsr16
   import jump_controller_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        step,
   output logic [15:0] value
);

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

   logic [15:0] r_value;

   // Sequence register: clear has priority over stepping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_value <= SEED_EFF;
      end else if (clr) begin
         r_value <= SEED_EFF;
      end else if (step) begin
         r_value <= lfsr_next(r_value);
      end
   end

   assign value = r_value;

endmodule

// File: rtl/jump_controller.sv
// Jump command FSM: key pulses to jump commands, reaction timer, score, game over.
module jump_controller
   import jump_controller_pkg::*;
#(
   parameter int unsigned TIMEOUT_MS = 1500,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter int unsigned SCORE_W    = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               module_en,
   input  logic               key_left,
   input  logic               key_right,
   input  logic               one_ms_tick,
   input  logic               landed,
   output logic               jump_left,
   output logic               jump_right,
   output logic               jump_fail,
   output logic               next_dir,
   output logic [SCORE_W-1:0] score,
   output logic [10:0]        time_left_ms,
   output logic               busy,
   output logic               game_over
);

   localparam logic [10:0] TO_RELOAD = 11'(TIMEOUT_MS);

   jc_state_t          r_state, w_state_nxt;
   logic [SCORE_W-1:0] r_score, w_score_nxt;
   logic [10:0]        r_time, w_time_nxt;
   logic               r_jl, r_jr, r_jf, r_busy, r_go;
   logic               w_jl_nxt, w_jr_nxt, w_jf_nxt, w_busy_nxt, w_go_nxt;
   logic               w_lfsr_step, w_clr, w_dir;
   logic [15:0]        w_lfsr;
   logic               w_unused_lfsr_hi;

   assign w_clr            = ~module_en;
   assign w_dir            = w_lfsr[0];
   assign w_unused_lfsr_hi = ^w_lfsr[15:1];

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_clr),
      .step  (w_lfsr_step),
      .value (w_lfsr)
   );

   // Next-state, timer, score and command-pulse decode.
   always_comb begin
      w_state_nxt = r_state;
      w_score_nxt = r_score;
      w_time_nxt  = r_time;
      w_jl_nxt    = 1'b0;
      w_jr_nxt    = 1'b0;
      w_jf_nxt    = 1'b0;
      w_go_nxt    = r_go;
      w_lfsr_step = 1'b0;
      case (r_state)
         S_WAIT: begin
            if (key_left && key_right) begin
               w_jf_nxt    = 1'b1;
               w_state_nxt = S_FALL;
            end else if (key_left || key_right) begin
               if (key_right == w_dir) begin
                  w_jl_nxt    = key_left;
                  w_jr_nxt    = key_right;
                  w_state_nxt = S_AIR;
               end else begin
                  w_jf_nxt    = 1'b1;
                  w_state_nxt = S_FALL;
               end
            end else if (one_ms_tick && (r_time != '0)) begin
               w_time_nxt = r_time - 11'd1;
               if (r_time == 11'd1) begin
                  w_jf_nxt    = 1'b1;
                  w_state_nxt = S_FALL;
               end
            end
         end
         S_AIR: begin
            if (landed) begin
               if (r_score != '1) begin
                  w_score_nxt = r_score + 1'b1;
               end
               w_lfsr_step = 1'b1;
               w_time_nxt  = TO_RELOAD;
               w_state_nxt = S_WAIT;
            end
         end
         S_FALL: begin
            if (landed) begin
               w_go_nxt    = 1'b1;
               w_state_nxt = S_OVER;
            end
         end
         default: begin
            w_state_nxt = S_OVER;
         end
      endcase
      w_busy_nxt = (w_state_nxt == S_AIR) || (w_state_nxt == S_FALL);
   end

   // State and registered outputs; module_en low acts as a synchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_WAIT;
         r_score <= '0;
         r_time  <= TO_RELOAD;
         r_jl    <= 1'b0;
         r_jr    <= 1'b0;
         r_jf    <= 1'b0;
         r_busy  <= 1'b0;
         r_go    <= 1'b0;
      end else if (!module_en) begin
         r_state <= S_WAIT;
         r_score <= '0;
         r_time  <= TO_RELOAD;
         r_jl    <= 1'b0;
         r_jr    <= 1'b0;
         r_jf    <= 1'b0;
         r_busy  <= 1'b0;
         r_go    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_score <= w_score_nxt;
         r_time  <= w_time_nxt;
         r_jl    <= w_jl_nxt;
         r_jr    <= w_jr_nxt;
         r_jf    <= w_jf_nxt;
         r_busy  <= w_busy_nxt;
         r_go    <= w_go_nxt;
      end
   end

   assign jump_left    = r_jl;
   assign jump_right   = r_jr;
   assign jump_fail    = r_jf;
   assign next_dir     = w_dir;
   assign score        = r_score;
   assign time_left_ms = r_time;
   assign busy         = r_busy;
   assign game_over    = r_go;

endmodule

// File: tb/tb_jump_controller.sv
// Self-checking bench for jump_controller: three instances (default,
// short timeout, 2-bit score) checked against a scenario-level model.
module tb_jump_controller;

   logic clk = 1'b0;
   logic rst;
   logic en[3], kl[3], kr[3], tk[3], ld[3];
   logic jl[3], jr[3], jf[3], nd[3], bz[3], go[3];
   logic [10:0] tl[3];
   logic [9:0]  sc0, sc1;
   logic [1:0]  sc2;

   int errors = 0;
   int checks = 0;

   // Reference model: sequence value, score and remaining time per instance.
   logic [15:0] m_lfsr[3];
   int          m_score[3];
   int          m_time[3];
   int          m_tmo[3]  = '{1500, 5, 1500};
   int          m_smax[3] = '{1023, 1023, 3};

   always #5 clk = ~clk;

   jump_controller u_dut0 (
      .clk(clk), .rst(rst), .module_en(en[0]), .key_left(kl[0]), .key_right(kr[0]),
      .one_ms_tick(tk[0]), .landed(ld[0]), .jump_left(jl[0]), .jump_right(jr[0]),
      .jump_fail(jf[0]), .next_dir(nd[0]), .score(sc0), .time_left_ms(tl[0]),
      .busy(bz[0]), .game_over(go[0]));

   jump_controller #(.TIMEOUT_MS(5)) u_dut1 (
      .clk(clk), .rst(rst), .module_en(en[1]), .key_left(kl[1]), .key_right(kr[1]),
      .one_ms_tick(tk[1]), .landed(ld[1]), .jump_left(jl[1]), .jump_right(jr[1]),
      .jump_fail(jf[1]), .next_dir(nd[1]), .score(sc1), .time_left_ms(tl[1]),
      .busy(bz[1]), .game_over(go[1]));

   jump_controller #(.SCORE_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .module_en(en[2]), .key_left(kl[2]), .key_right(kr[2]),
      .one_ms_tick(tk[2]), .landed(ld[2]), .jump_left(jl[2]), .jump_right(jr[2]),
      .jump_fail(jf[2]), .next_dir(nd[2]), .score(sc2), .time_left_ms(tl[2]),
      .busy(bz[2]), .game_over(go[2]));

   function automatic logic [15:0] model_step(input logic [15:0] v);
      int x;
      x = int'(v) / 2;
      if (v % 2 == 1) x = x ^ 'hB400;
      return 16'(x);
   endfunction

   function automatic int get_score(input int i);
      if (i == 0) return int'(sc0);
      if (i == 1) return int'(sc1);
      return int'(sc2);
   endfunction

   function automatic logic [2:0] pulses(input int i);
      return {jl[i], jr[i], jf[i]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_lfsr[i]  = 16'hACE1;
         m_score[i] = 0;
         m_time[i]  = m_tmo[i];
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   task automatic press(input int i, input logic l, input logic r, input logic t);
      kl[i] = l; kr[i] = r; tk[i] = t;
      @(negedge clk);
      kl[i] = 1'b0; kr[i] = 1'b0; tk[i] = 1'b0;
   endtask

   task automatic land(input int i);
      ld[i] = 1'b1;
      @(negedge clk);
      ld[i] = 1'b0;
   endtask

   // Ticks while waiting; each must decrement the visible timer by one.
   task automatic tick_wait(input int i, input int n);
      for (int k = 0; k < n; k++) begin
         tk[i] = 1'b1;
         @(negedge clk);
         tk[i] = 1'b0;
         m_time[i]--;
         checks++;
         if (int'(tl[i]) !== m_time[i]) begin
            errors++;
            $display("FAIL tick_wait[%0d] time_left_ms got %0d want %0d", i, tl[i], m_time[i]);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   // Random key/tick activity while airborne or falling: no command may appear.
   task automatic noise_no_pulse(input int i, input int n, input string tag);
      for (int c = 0; c < n; c++) begin
         kl[i] = 1'($urandom_range(0, 1));
         kr[i] = 1'($urandom_range(0, 1));
         tk[i] = 1'($urandom_range(0, 1));
         @(negedge clk);
         kl[i] = 1'b0; kr[i] = 1'b0; tk[i] = 1'b0;
         checks++;
         if (pulses(i) !== 3'b000) begin
            errors++;
            $display("FAIL %s[%0d] pulses got %b want 000", tag, i, pulses(i));
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({pulses(i), bz[i], go[i]} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_flags[%0d] got %b want 00000", i, {pulses(i), bz[i], go[i]});
         end
         checks++;
         if (int'(tl[i]) !== m_tmo[i] || get_score(i) !== 0) begin
            errors++;
            $display("FAIL reset_time_score[%0d] got %0d/%0d want %0d/0", i, tl[i], get_score(i), m_tmo[i]);
         end
         checks++;
         if (nd[i] !== 1'b1) begin
            errors++;
            $display("FAIL reset_next_dir[%0d] got %b want 1", i, nd[i]);
         end
      end
      #1;
      rst = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   task automatic test_first_jump();
      do_reset();
      press(0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (pulses(0) !== 3'b010 || bz[0] !== 1'b1) begin
         errors++;
         $display("FAIL first_jump_right got pulses=%b busy=%b want 010/1", pulses(0), bz[0]);
      end
      @(negedge clk);
      checks++;
      if (pulses(0) !== 3'b000) begin
         errors++;
         $display("FAIL first_jump_single got %b want 000", pulses(0));
      end
      for (int k = 0; k < 80; k++) begin
         tk[0] = 1'b1;
         @(negedge clk);
         tk[0] = 1'b0;
      end
      checks++;
      if (int'(tl[0]) !== 1500) begin
         errors++;
         $display("FAIL first_air_time got %0d want 1500", tl[0]);
      end
      land(0);
      m_lfsr[0] = model_step(m_lfsr[0]);
      checks++;
      if (get_score(0) !== 1 || int'(tl[0]) !== 1500 || nd[0] !== m_lfsr[0][0] || bz[0] !== 1'b0) begin
         errors++;
         $display("FAIL first_land got score=%0d time=%0d dir=%b busy=%b want 1/1500/%b/0",
                  get_score(0), tl[0], nd[0], m_lfsr[0][0], bz[0]);
      end
      m_score[0] = 1;
   endtask

   task automatic test_correct_jumps(input int i, input int n);
      logic d;
      logic t;
      for (int j = 0; j < n; j++) begin
         tick_wait(i, $urandom_range(0, 3));
         d = m_lfsr[i][0];
         checks++;
         if (nd[i] !== d) begin
            errors++;
            $display("FAIL jump_dir[%0d] got %b want %b", i, nd[i], d);
         end
         t = 1'($urandom_range(0, 1));
         press(i, ~d, d, t);
         checks++;
         if (pulses(i) !== (d ? 3'b010 : 3'b100) || bz[i] !== 1'b1 || int'(tl[i]) !== m_time[i]) begin
            errors++;
            $display("FAIL jump_cmd[%0d] got pulses=%b busy=%b time=%0d want %b/1/%0d",
                     i, pulses(i), bz[i], tl[i], (d ? 3'b010 : 3'b100), m_time[i]);
         end
         noise_no_pulse(i, $urandom_range(2, 6), "air_noise");
         land(i);
         m_lfsr[i]  = model_step(m_lfsr[i]);
         m_score[i] = (m_score[i] + 1 > m_smax[i]) ? m_smax[i] : m_score[i] + 1;
         m_time[i]  = m_tmo[i];
         checks++;
         if (get_score(i) !== m_score[i] || int'(tl[i]) !== m_time[i] || nd[i] !== m_lfsr[i][0] || bz[i] !== 1'b0) begin
            errors++;
            $display("FAIL jump_land[%0d] got score=%0d time=%0d dir=%b busy=%b want %0d/%0d/%b/0",
                     i, get_score(i), tl[i], nd[i], bz[i], m_score[i], m_time[i], m_lfsr[i][0]);
         end
      end
   endtask

   task automatic fail_and_land(input int i, input logic l, input logic r, input string tag);
      press(i, l, r, 1'b0);
      checks++;
      if (pulses(i) !== 3'b001 || bz[i] !== 1'b1) begin
         errors++;
         $display("FAIL %s_cmd[%0d] got pulses=%b busy=%b want 001/1", tag, i, pulses(i), bz[i]);
      end
      noise_no_pulse(i, 3, "fall_noise");
      land(i);
      checks++;
      if (go[i] !== 1'b1 || bz[i] !== 1'b0) begin
         errors++;
         $display("FAIL %s_over[%0d] got game_over=%b busy=%b want 1/0", tag, i, go[i], bz[i]);
      end
   endtask

   task automatic test_wrong_key();
      do_reset();
      tick_wait(0, 2);
      fail_and_land(0, m_lfsr[0][0], ~m_lfsr[0][0], "wrong_key");
      for (int c = 0; c < 6; c++) begin
         kl[0] = 1'($urandom_range(0, 1));
         kr[0] = 1'($urandom_range(0, 1));
         tk[0] = 1'($urandom_range(0, 1));
         ld[0] = 1'($urandom_range(0, 1));
         @(negedge clk);
         kl[0] = 1'b0; kr[0] = 1'b0; tk[0] = 1'b0; ld[0] = 1'b0;
         checks++;
         if (pulses(0) !== 3'b000 || go[0] !== 1'b1 || get_score(0) !== 0) begin
            errors++;
            $display("FAIL over_idle got pulses=%b game_over=%b score=%0d want 000/1/0",
                     pulses(0), go[0], get_score(0));
         end
      end
   endtask

   task automatic test_both_keys();
      do_reset();
      test_correct_jumps(0, 1);
      fail_and_land(0, 1'b1, 1'b1, "both_keys");
   endtask

   task automatic test_timeout();
      int want;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         tk[1] = 1'b1;
         @(negedge clk);
         tk[1] = 1'b0;
         want = 4 - k;
         checks++;
         if (int'(tl[1]) !== want || jf[1] !== (k == 4)) begin
            errors++;
            $display("FAIL timeout_tick%0d got time=%0d fail=%b want %0d/%b", k, tl[1], jf[1], want, (k == 4));
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      @(negedge clk);
      checks++;
      if (pulses(1) !== 3'b000 || int'(tl[1]) !== 0 || bz[1] !== 1'b1) begin
         errors++;
         $display("FAIL timeout_hold got pulses=%b time=%0d busy=%b want 000/0/1", pulses(1), tl[1], bz[1]);
      end
      land(1);
      checks++;
      if (go[1] !== 1'b1) begin
         errors++;
         $display("FAIL timeout_over got %b want 1", go[1]);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      test_correct_jumps(2, 5);
      checks++;
      if (get_score(2) !== 3) begin
         errors++;
         $display("FAIL score_saturate got %0d want 3", get_score(2));
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      press(0, ~m_lfsr[0][0], m_lfsr[0][0], 1'b0);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({pulses(0), bz[0], go[0]} !== 5'b00000 || int'(tl[0]) !== 1500 || get_score(0) !== 0) begin
         errors++;
         $display("FAIL async_rst got flags=%b time=%0d score=%0d want 00000/1500/0",
                  {pulses(0), bz[0], go[0]}, tl[0], get_score(0));
      end
      #1;
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      land(0);
      checks++;
      if ({pulses(0), bz[0], go[0]} !== 5'b00000 || get_score(0) !== 0 || nd[0] !== m_lfsr[0][0]) begin
         errors++;
         $display("FAIL late_landed got flags=%b score=%0d dir=%b want 00000/0/%b",
                  {pulses(0), bz[0], go[0]}, get_score(0), nd[0], m_lfsr[0][0]);
      end
   endtask

   task automatic test_enable_clear();
      do_reset();
      test_correct_jumps(0, 2);
      fail_and_land(0, m_lfsr[0][0], ~m_lfsr[0][0], "pre_clear");
      en[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (go[0] !== 1'b0 || bz[0] !== 1'b0 || get_score(0) !== 0 || int'(tl[0]) !== 1500 || nd[0] !== 1'b1) begin
         errors++;
         $display("FAIL en_clear got go=%b busy=%b score=%0d time=%0d dir=%b want 0/0/0/1500/1",
                  go[0], bz[0], get_score(0), tl[0], nd[0]);
      end
      en[0] = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         en[i] = 1'b1; kl[i] = 1'b0; kr[i] = 1'b0; tk[i] = 1'b0; ld[i] = 1'b0;
      end
      model_reset();
      test_reset();
      test_first_jump();
      test_correct_jumps(0, 6);
      test_wrong_key();
      test_both_keys();
      test_timeout();
      test_saturation();
      test_async_reset();
      test_enable_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
